branch_ctrl: RTL
================

# branch_ctrl

Branch and wait controller for the pico-MIPS core. It sits directly upstream of the program counter and drives the PC's `rel_branch` and `offset` inputs. It holds the ALU condition flags and evaluates conditional and unconditional relative branches against them. It also implements the wait-for-switch instructions by holding the PC on the current instruction until a synchronised, debounced switch input reaches the requested level.

## Interface
Parameters:
- `AddrSz`, 6: width of the PC address, the immediate and `offset`.
- `DbCycles`, 4: number of consecutive differing samples needed to accept a switch change. Legal range ≥ 2.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `br_op`, input, 3: branch class from the decoder.
  - 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BRA, 5 WAITH, 6 WAITL.
  - 7 is reserved and behaves as NONE.
- `imm`, input, `AddrSz`: two's-complement branch displacement.
- `flag_we`, input, 1: latch `alu_z` and `alu_n` at this edge.
- `alu_z`, input, 1: ALU zero result.
- `alu_n`, input, 1: ALU negative result.
- `sw_in`, input, 1: raw, asynchronous switch/button.
- `rel_branch`, output, 1: goes to the PC. When 1, the PC adds `offset`; when 0, the PC increments.
- `offset`, output, `AddrSz`: goes to the PC.
- `sw_db`, output, 1: debounced switch level, exported for status.

## Operation
- State:
  - flag register `z_q`, `n_q`
  - 2-flop synchroniser `s1`, `s2`
  - debounce counter `cnt`, width `$clog2(DbCycles)`
  - debounced level `sw_db`
- Reset (asynchronous, while `n_reset` is low): `z_q`, `n_q`, `s1`, `s2`, `cnt` and `sw_db` all clear to 0.
- Flags:
  - On a rising edge with `flag_we`=1: `z_q`<=`alu_z` and `n_q`<=`alu_n`.
  - Otherwise the flags hold.
  - Branch decisions always use the registered flags. A branch in the same cycle as `flag_we` sees the old flags.
- Branch decode (combinational from `br_op`, `imm`, flags and `sw_db`):
  - NONE/7: `rel_branch`=0, `offset`=0.
  - BEQ: taken iff `z_q`=1.
  - BNE: taken iff `z_q`=0.
  - BLT: taken iff `n_q`=1.
  - BRA: always taken.
  - Taken: `rel_branch`=1, `offset`=`imm`.
  - Not taken: `rel_branch`=0, `offset`=0.
  - `offset` is passed through unmodified. Wrap-around is modulo 2^`AddrSz` in the PC; for example, `imm`=6'h3F moves the PC back by 1.
- Wait:
  - WAITH while `sw_db`=0, and WAITL while `sw_db`=1: `rel_branch`=1, `offset`=0. This is a branch-to-self, so the PC holds.
  - Once the condition is met: `rel_branch`=0, `offset`=0, and the PC advances.
- Debounce, on each rising edge:
  - `s1`<=`sw_in` and `s2`<=`s1`.
  - If `s2`==`sw_db`: `cnt`<=0.
  - Else, if `cnt`==`DbCycles`-1: `sw_db`<=`s2` and `cnt`<=0.
  - Else: `cnt`<=`cnt`+1.
  - Any glitch that returns `s2` to `sw_db` before acceptance restarts the count.
- Debounce runs independently of `br_op`. A switch change during a non-wait instruction is still tracked.

## Timing
- `rel_branch` and `offset` are purely combinational, with zero latency. The PC registers them on the next edge.
- Flag latency: a `flag_we` at edge k affects branch decode from just after edge k.
- Switch latency: if `sw_in` changes and stays stable before edge 1, then `s2` updates at edge 2 and `sw_db` updates at edge 2+`DbCycles` (edge 6 at default).
- The waiting PC advances on the edge after `sw_db` satisfies the condition.
- Reset mid-wait:
  - `sw_db` returns to 0 immediately.
  - WAITL is released at once (`rel_branch`=0).
  - WAITH holds again.
  - Outputs remain a function of `br_op` at all times; no output is registered.

## Test plan
- Reset, then `br_op`=NONE for 5 cycles → `rel_branch`=0, `offset`=0 every cycle; `sw_db`=0.
- `flag_we`=1 with `alu_z`=1 at edge k, then BEQ with `imm`=10 → `rel_branch`=1, `offset`=10. BNE with `imm`=10 → `rel_branch`=0, `offset`=0.
- BEQ in the same cycle as `flag_we`=1, `alu_z`=1, with `z_q` previously 0 → not taken that cycle; taken on the following cycle if BEQ is held.
- BLT with `n_q`=1 and `imm`=6'h3E → `rel_branch`=1, `offset`=6'h3E. BRA with `imm`=3 → taken regardless of flags.
- WAITH with `sw_in` raised and held 1 → `rel_branch`=1 with `offset`=0 through edge 5. `sw_db`=1 after edge 6, after which `rel_branch`=0.
- `sw_in` pulse of 2 cycles during WAITH → `sw_db` stays 0 and `rel_branch` stays 1. Assert `n_reset`=0 during a WAITL with `sw_db`=1 → `sw_db`=0 and `rel_branch`=0 immediately.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch and wait controller feeding the pico-MIPS program counter.
// Holds ALU flags, decodes relative branches, and debounces the wait switch.
module branch_ctrl #(
    parameter int AddrSz   = 6,
    parameter int DbCycles = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [2:0]        br_op,
    input  logic [AddrSz-1:0] imm,
    input  logic              flag_we,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              sw_in,
    output logic              rel_branch,
    output logic [AddrSz-1:0] offset,
    output logic              sw_db
);

    localparam int CntW = (DbCycles > 1) ? $clog2(DbCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DbCycles - 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_BEQ   = 3'd1,
        OP_BNE   = 3'd2,
        OP_BLT   = 3'd3,
        OP_BRA   = 3'd4,
        OP_WAITH = 3'd5,
        OP_WAITL = 3'd6,
        OP_RSVD  = 3'd7
    } br_op_e;

    logic            r_z;
    logic            r_n;
    logic            r_s1;
    logic            r_s2;
    logic [CntW-1:0] r_cnt;
    logic            r_sw_db;

    logic            w_taken;
    logic            w_hold;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (flag_we) begin
            r_z <= alu_z;
            r_n <= alu_n;
        end
    end

    // Any return of s2 to the accepted level before the count completes restarts it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_sw_db <= 1'b0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
            if (r_s2 == r_sw_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CntMax) begin
                r_sw_db <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        w_hold  = 1'b0;
        case (br_op_e'(br_op))
            OP_BEQ:   w_taken = r_z;
            OP_BNE:   w_taken = !r_z;
            OP_BLT:   w_taken = r_n;
            OP_BRA:   w_taken = 1'b1;
            OP_WAITH: w_hold  = !r_sw_db;
            OP_WAITL: w_hold  = r_sw_db;
            default: begin
                w_taken = 1'b0;
                w_hold  = 1'b0;
            end
        endcase
    end

    // A wait is a branch-to-self: rel_branch with a zero offset.
    assign rel_branch = w_taken | w_hold;
    assign offset     = w_taken ? imm : '0;
    assign sw_db      = r_sw_db;

endmodule
